// File: rtl/ok_stream_out_bridge.sv
// ok_stream_out_bridge
// Buffers emulator output words in a small FIFO and presents the head word,
// tagged with a nonzero sequence number, to host wire-outs. The host pops the
// head by echoing that sequence number on host_ack_seq.
// Optional statistics counters are enabled by defining OK_STREAM_STATS_EN.
module ok_stream_out_bridge #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 4
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_bits,
    input  logic [7:0]        host_ack_seq,
    input  logic              host_flush,
    output logic              wo_valid,
    output logic [DATA_W-1:0] wo_data,
    output logic [7:0]        wo_seq,
    output logic [4:0]        wo_count
`ifdef OK_STREAM_STATS_EN
    ,
    output logic [15:0]       stat_accepted,
    output logic [15:0]       stat_stall
`endif
);

    localparam int         PTR_W     = $clog2(DEPTH);
    localparam logic [4:0] COUNT_MAX = 5'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              ready_en;
    logic              push;
    logic              pop;

    // Sequence numbers skip 0 so the host's reset value never acks a word.
    function automatic logic [7:0] next_seq(input logic [7:0] s);
        return (s == 8'd255) ? 8'd1 : s + 8'd1;
    endfunction

    // Handshake decode: readiness depends only on registered occupancy.
    always_comb begin
        in_ready = ready_en && (wo_count < COUNT_MAX) && !host_flush;
        wo_valid = (wo_count != 5'd0);
        wo_data  = wo_valid ? mem[rd_ptr] : '0;
        push     = in_valid && in_ready;
        pop      = wo_valid && (host_ack_seq == wo_seq) && !host_flush;
    end

    // FIFO storage; contents are only meaningful while counted, so no reset.
    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr] <= in_bits;
        end
    end

    // Pointers, occupancy, sequence number and post-reset ready enable.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            wo_count <= 5'd0;
            wo_seq   <= 8'd1;
            ready_en <= 1'b0;
        end else begin
            ready_en <= 1'b1;
            if (host_flush) begin
                rd_ptr   <= wr_ptr;
                wo_count <= 5'd0;
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + PTR_W'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + PTR_W'(1);
                    wo_seq <= next_seq(wo_seq);
                end
                case ({push, pop})
                    2'b10:   wo_count <= wo_count + 5'd1;
                    2'b01:   wo_count <= wo_count - 5'd1;
                    default: wo_count <= wo_count;
                endcase
            end
        end
    end

`ifdef OK_STREAM_STATS_EN
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Saturating counters of accepted words and stalled offers; survive flush.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            stat_accepted <= 16'd0;
            stat_stall    <= 16'd0;
        end else begin
            if (push) begin
                stat_accepted <= sat_inc(stat_accepted);
            end
            if (in_valid && !in_ready) begin
                stat_stall <= sat_inc(stat_stall);
            end
        end
    end
`endif

endmodule

// File: tb/tb_ok_stream_out_bridge.sv
// Directed self-checking bench for ok_stream_out_bridge (DATA_W=16, DEPTH=4).
// Define OK_STREAM_STATS_EN for both files to exercise the stats counters.
module tb_ok_stream_out_bridge;

    logic        clock;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_bits;
    logic [7:0]  host_ack_seq;
    logic        host_flush;
    logic        wo_valid;
    logic [15:0] wo_data;
    logic [7:0]  wo_seq;
    logic [4:0]  wo_count;
`ifdef OK_STREAM_STATS_EN
    logic [15:0] stat_accepted;
    logic [15:0] stat_stall;
`endif

    int checks = 0;
    int errors = 0;

    ok_stream_out_bridge #(.DATA_W(16), .DEPTH(4)) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_bits      (in_bits),
        .host_ack_seq (host_ack_seq),
        .host_flush   (host_flush),
        .wo_valid     (wo_valid),
        .wo_data      (wo_data),
        .wo_seq       (wo_seq),
        .wo_count     (wo_count)
`ifdef OK_STREAM_STATS_EN
        ,
        .stat_accepted(stat_accepted),
        .stat_stall   (stat_stall)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance through one rising edge; returns at the following falling edge.
    task automatic step();
        @(negedge clock);
    endtask

    function automatic logic [7:0] seq_after(input logic [7:0] s);
        return (s == 8'd255) ? 8'd1 : s + 8'd1;
    endfunction

    logic [7:0]  exp_seq;
    logic [15:0] word;

    initial begin
        reset_n      = 1'b0;
        in_valid     = 1'b0;
        in_bits      = 16'h0;
        host_ack_seq = 8'd0;
        host_flush   = 1'b0;
        step();
        step();
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_wo_valid", 32'(wo_valid), 32'd0);
        chk("rst_wo_data",  32'(wo_data),  32'd0);
        chk("rst_wo_seq",   32'(wo_seq),   32'd1);
        chk("rst_wo_count", 32'(wo_count), 32'd0);
        reset_n = 1'b1;
        step();
        chk("rel_in_ready", 32'(in_ready), 32'd1);

        // Single word appears one cycle after the push edge.
        in_valid = 1'b1; in_bits = 16'hA5A5;
        step();
        in_valid = 1'b0;
        chk("first_valid", 32'(wo_valid), 32'd1);
        chk("first_data",  32'(wo_data),  32'hA5A5);
        chk("first_seq",   32'(wo_seq),   32'd1);
        chk("first_count", 32'(wo_count), 32'd1);

        // Held ack pops exactly once.
        in_valid = 1'b1; in_bits = 16'h1234;
        step();
        in_valid = 1'b0;
        chk("two_count", 32'(wo_count), 32'd2);
        host_ack_seq = 8'd1;
        repeat (5) step();
        chk("hold_seq",   32'(wo_seq),   32'd2);
        chk("hold_data",  32'(wo_data),  32'h1234);
        chk("hold_count", 32'(wo_count), 32'd1);
        host_ack_seq = 8'd2;
        step();
        chk("drain_count", 32'(wo_count), 32'd0);
        chk("drain_valid", 32'(wo_valid), 32'd0);
        chk("drain_data",  32'(wo_data),  32'd0);
        chk("drain_seq",   32'(wo_seq),   32'd3);
        // Matching ack while empty changes nothing.
        host_ack_seq = 8'd3;
        repeat (3) step();
        chk("empty_ack_seq",   32'(wo_seq),   32'd3);
        chk("empty_ack_count", 32'(wo_count), 32'd0);
        host_ack_seq = 8'd0;

        // Fill to DEPTH, hold a fifth offer, then free one slot.
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_bits = 16'h1000 + 16'(i);
            step();
        end
        chk("full_count", 32'(wo_count), 32'd4);
        chk("full_ready", 32'(in_ready), 32'd0);
        in_bits = 16'h1004;
        repeat (2) step();
        chk("held_count", 32'(wo_count), 32'd4);
        host_ack_seq = 8'd3;
        step();
        chk("unfull_ready", 32'(in_ready), 32'd1);
        chk("unfull_count", 32'(wo_count), 32'd3);
        chk("unfull_seq",   32'(wo_seq),   32'd4);
        chk("unfull_data",  32'(wo_data),  32'h1001);
        step();
        in_valid = 1'b0;
        chk("refill_count", 32'(wo_count), 32'd4);
        exp_seq = 8'd4;
        for (int i = 1; i <= 4; i++) begin
            chk("order_data", 32'(wo_data), 32'h1000 + 32'(i));
            chk("order_seq",  32'(wo_seq),  32'(exp_seq));
            host_ack_seq = exp_seq;
            step();
            exp_seq = seq_after(exp_seq);
        end
        chk("order_count", 32'(wo_count), 32'd0);
        host_ack_seq = 8'd0;

        // 256 round trips exercise the 255 -> 1 wrap.
        for (int i = 0; i < 256; i++) begin
            word = 16'h2000 + 16'(i * 13);
            in_valid = 1'b1; in_bits = word;
            step();
            in_valid = 1'b0;
            chk("rt_data", 32'(wo_data), 32'(word));
            chk("rt_seq",  32'(wo_seq),  32'(exp_seq));
            if (wo_seq == 8'd0) chk("rt_seq_zero", 32'(wo_seq), 32'd1);
            host_ack_seq = exp_seq;
            step();
            exp_seq = seq_after(exp_seq);
        end
        chk("rt_count", 32'(wo_count), 32'd0);
        chk("rt_seq_end", 32'(wo_seq), 32'(exp_seq));
        host_ack_seq = 8'd0;

        // Simultaneous push and pop keep occupancy.
        in_valid = 1'b1; in_bits = 16'h55AA;
        step();
        in_bits = 16'h66BB; host_ack_seq = exp_seq;
        step();
        in_valid = 1'b0;
        exp_seq = seq_after(exp_seq);
        chk("pp_count", 32'(wo_count), 32'd1);
        chk("pp_data",  32'(wo_data),  32'h66BB);
        chk("pp_seq",   32'(wo_seq),   32'(exp_seq));
        host_ack_seq = exp_seq;
        step();
        exp_seq = seq_after(exp_seq);
        host_ack_seq = 8'd0;
        chk("pp_drain", 32'(wo_count), 32'd0);

        // Flush with three words queued and an offer pending.
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_bits = 16'h3000 + 16'(i);
            step();
        end
        in_bits = 16'h7777; host_flush = 1'b1;
        #1;
        chk("flush_ready", 32'(in_ready), 32'd0);
        step();
        chk("flush_count", 32'(wo_count), 32'd0);
        chk("flush_valid", 32'(wo_valid), 32'd0);
        chk("flush_seq",   32'(wo_seq),   32'(exp_seq));
        host_flush = 1'b0; in_bits = 16'h8888;
        step();
        in_valid = 1'b0;
        chk("post_flush_data",  32'(wo_data),  32'h8888);
        chk("post_flush_count", 32'(wo_count), 32'd1);

        // Reset in mid-transfer discards contents and restarts numbering.
        reset_n = 1'b0;
        #1;
        chk("mid_rst_count", 32'(wo_count), 32'd0);
        chk("mid_rst_valid", 32'(wo_valid), 32'd0);
        chk("mid_rst_data",  32'(wo_data),  32'd0);
        chk("mid_rst_seq",   32'(wo_seq),   32'd1);
        chk("mid_rst_ready", 32'(in_ready), 32'd0);
        step();
        reset_n = 1'b1;
        step();
        chk("mid_rel_ready", 32'(in_ready), 32'd1);
        chk("mid_rel_seq",   32'(wo_seq),   32'd1);
        chk("mid_rel_count", 32'(wo_count), 32'd0);

`ifdef OK_STREAM_STATS_EN
        chk("stat_acc_rst",   32'(stat_accepted), 32'd0);
        chk("stat_stall_rst", 32'(stat_stall),    32'd0);
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_bits = 16'h4000 + 16'(i);
            step();
        end
        host_flush = 1'b1;
        repeat (10) step();
        in_valid = 1'b0; host_flush = 1'b0;
        chk("stat_acc",   32'(stat_accepted), 32'd3);
        chk("stat_stall", 32'(stat_stall),    32'd10);
        force dut.stat_accepted = 16'hFFFF;
        #1;
        release dut.stat_accepted;
        in_valid = 1'b1; in_bits = 16'h4444;
        step();
        in_valid = 1'b0;
        chk("stat_acc_sat", 32'(stat_accepted), 32'hFFFF);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ok_stream_out_bridge.md
OK_STREAM_OUT_BRIDGE -- requirements
Module: ok_stream_out_bridge

Interface
REQ-001 SHALL have parameter DATA_W, default 16: width of the stream word and of wo_data.
REQ-002 SHALL have parameter DEPTH, default 4: number of FIFO entries; legal values are powers of two from 2 to 16.
REQ-003 SHALL have port clock, input, width 1: the single clock; one clock; reset is asynchronous and active-low.
REQ-004 SHALL have port reset_n, input, width 1: asynchronous active-low reset.
REQ-005 SHALL have port in_valid, input, width 1: emulator output word valid (io_o side).
REQ-006 SHALL have port in_ready, output, width 1: bridge can accept a word.
REQ-007 SHALL have port in_bits, input, width DATA_W: emulator output word.
REQ-008 SHALL have port host_ack_seq, input, width 8: host wire-in; the sequence number of the last word the host consumed.
REQ-009 SHALL have port host_flush, input, width 1: host wire-in bit that synchronously discards the FIFO contents.
REQ-010 SHALL have port wo_valid, output, width 1: head word presented to the host wire-out.
REQ-011 SHALL have port wo_data, output, width DATA_W: head word.
REQ-012 SHALL have port wo_seq, output, width 8: sequence number of the presented word.
REQ-013 SHALL have port wo_count, output, width 5: FIFO occupancy, 0..DEPTH.

Function
REQ-014 SHALL drive in_ready = (wo_count < DEPTH) && !host_flush, purely from current state, with no dependency on a same-cycle pop.
REQ-015 SHALL push in_bits into the FIFO tail on every rising clock edge where in_valid && in_ready.
REQ-016 SHALL drive wo_valid = (wo_count != 0), and drive wo_data from the FIFO head when valid and 0 when empty.
REQ-017 SHALL present a word pushed into an empty FIFO at edge N on wo_data/wo_valid after edge N, giving 1-cycle latency.
REQ-018 SHALL pop the head at an edge where wo_valid && host_ack_seq == wo_seq && !host_flush, with at most one pop per cycle.
REQ-019 SHALL increment wo_seq on each pop, wrapping 255 -> 1 so that the value 0 is never issued.
REQ-020 SHALL ignore a stale host_ack_seq that no longer matches after a pop; a held ack value never pops twice.
REQ-021 SHALL leave the FIFO and wo_seq unchanged when host_ack_seq matches while wo_valid=0.
REQ-022 SHALL apply both a push and a pop in the same cycle when they coincide, leaving wo_count unchanged and updating head and tail pointers independently.
REQ-023 SHALL, on host_flush=1 at an edge, set wo_count to 0 and set the read pointer equal to the write pointer, with no push and no pop that cycle and wo_seq unchanged.
REQ-024 SHALL use DEPTH-wrapping read and write pointers, with occupancy tracked by a separate counter.

Reset
REQ-025 SHALL, while reset_n=0, asynchronously force pointers=0, wo_count=0, wo_valid=0, wo_data=0, wo_seq=1, and in_ready=0.
REQ-026 SHALL raise in_ready in the first cycle after reset_n deasserts, provided host_flush=0.
REQ-027 SHALL discard all FIFO contents when reset is asserted mid-transfer, and SHALL NOT pop on the host wire-in reset value of 0, because wo_seq restarts at 1.

Configuration
REQ-028 SHALL, when macro OK_STREAM_STATS_EN is defined, add output stat_accepted (16 bits) and output stat_stall (16 bits).
REQ-029 SHALL increment stat_accepted on each push and stat_stall on each cycle with in_valid && !in_ready, both saturating at 16'hFFFF.
REQ-030 SHALL reset both stat counters to 0 on reset_n and SHALL NOT clear them on host_flush.
REQ-031 SHALL NOT have the stat ports or the counter logic when OK_STREAM_STATS_EN is undefined, with all other behaviour identical.

Verification
REQ-032 SHALL cover: reset release, push 16'hA5A5 -> next cycle wo_valid=1, wo_data=16'hA5A5, wo_seq=1, wo_count=1.
REQ-033 SHALL cover: set host_ack_seq=1 and hold it for 5 cycles with 2 words queued -> exactly one pop, wo_seq=2, wo_data=second word, wo_count=1.
REQ-034 SHALL cover: push 4 words with no ack (DEPTH=4) -> in_ready=0, wo_count=4; a 5th in_valid is held; ack 1 -> in_ready=1 the next cycle; the 5th word is accepted without loss or reordering.
REQ-035 SHALL cover: 256 push/ack round trips -> wo_seq sequence 1..255, 1, 2, never 0, and data matches input order.
REQ-036 SHALL cover: host_flush=1 with 3 words queued and in_valid=1 -> in_ready=0 that cycle, wo_count=0 after the edge, wo_seq unchanged.
REQ-037 SHALL cover, with OK_STREAM_STATS_EN defined: 3 pushes plus 10 full-stall cycles -> stat_accepted=3, stat_stall=10; a forced count of 16'hFFFF holds at 16'hFFFF.
